fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and instruction-format defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Fetch FSM states: opcode fetch, operand fetch, present to decoder, halted.
  typedef enum logic [1:0] {
    S_OPC  = 2'd0,
    S_OPR  = 2'd1,
    S_OUT  = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  // Opcode bit that marks a two-byte (opcode + operand) instruction.
  localparam int LONG_OP_BIT_DEF = 7;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: reads 1- or 2-byte instructions, steps program_counter, hands them to decode.
// Latency: instruction valid 1 cycle after the last byte ack; zero-wait acks accepted same cycle.
// Backpressure: ir_ready=0 holds the instruction in S_OUT; mem_req/mem_addr hold until mem_ack.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   pc / pc_next / pc_enable        program_counter interface (load pc_next when pc_enable)
//   mem_req/mem_addr/mem_ack/mem_rdata  instruction memory read port
//   ir_valid/ir_ready/ir_opcode/ir_operand/ir_pc  instruction handoff to decoder
//   branch_taken/branch_target      redirect from execute, highest priority
//   halt                            stop fetching at the next instruction boundary
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int LONG_OP_BIT = LONG_OP_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc,
  output logic [7:0] pc_next,
  output logic       pc_enable,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic [7:0] ir_opcode,
  output logic [7:0] ir_operand,
  output logic [7:0] ir_pc,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       halt
);

  fetch_state_t r_state;
  logic [7:0]   r_ir_opcode;
  logic [7:0]   r_ir_operand;
  logic [7:0]   r_ir_pc;

  logic         w_mem_req;
  logic         w_byte_done;

  // A branch kills the request in the same cycle so a coincident ack cannot be consumed.
  assign w_mem_req = !reset && !branch_taken &&
                     (((r_state == S_OPC) && !halt) || (r_state == S_OPR));

  // Only an ack against our own live request counts; stray acks are dropped.
  assign w_byte_done = w_mem_req && mem_ack;

  assign mem_req    = w_mem_req;
  assign mem_addr   = pc;
  assign ir_valid   = (r_state == S_OUT);
  assign ir_opcode  = r_ir_opcode;
  assign ir_operand = r_ir_operand;
  assign ir_pc      = r_ir_pc;

  always_comb begin
    pc_next   = pc;
    pc_enable = 1'b0;
    if (!reset) begin
      if (branch_taken) begin
        pc_next   = branch_target;
        pc_enable = 1'b1;
      end else if (w_byte_done) begin
        pc_next   = pc + 8'd1;  // 8-bit add wraps FF -> 00
        pc_enable = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_OPC;
      r_ir_opcode  <= 8'h00;
      r_ir_operand <= 8'h00;
      r_ir_pc      <= 8'h00;
    end else if (branch_taken) begin
      r_state <= halt ? S_HALT : S_OPC;
    end else begin
      case (r_state)
        S_OPC: begin
          if (halt) begin
            r_state <= S_HALT;
          end else if (mem_ack) begin
            r_ir_opcode <= mem_rdata;
            r_ir_pc     <= pc;
            if (mem_rdata[LONG_OP_BIT]) begin
              r_state <= S_OPR;
            end else begin
              r_ir_operand <= 8'h00;
              r_state      <= S_OUT;
            end
          end
        end
        S_OPR: begin
          // halt is deliberately ignored here: an instruction is never split.
          if (mem_ack) begin
            r_ir_operand <= mem_rdata;
            r_state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (ir_ready) begin
            r_state <= halt ? S_HALT : S_OPC;
          end
        end
        S_HALT: begin
          if (!halt) begin
            r_state <= S_OPC;
          end
        end
        default: r_state <= S_OPC;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a program_counter model and a latency-programmable memory.
// Latency: n/a.
// Backpressure: ir_ready driven per scenario.
module tb_fetch_unit;

  logic       clk;
  logic       reset;
  logic [7:0] pc;
  logic [7:0] pc_next;
  logic       pc_enable;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       ir_valid;
  logic       ir_ready;
  logic [7:0] ir_opcode;
  logic [7:0] ir_operand;
  logic [7:0] ir_pc;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       halt;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.LONG_OP_BIT(7)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pc_next       (pc_next),
    .pc_enable     (pc_enable),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_opcode     (ir_opcode),
    .ir_operand    (ir_operand),
    .ir_pc         (ir_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program_counter model
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= 8'h00;
    else if (pc_enable) pc <= pc_next;
  end

  // Memory: ack after lat_wait extra cycles of continuous request; ack_force injects stray acks.
  logic [7:0] mem [256];
  int         lat_wait = 0;
  int         wcnt = 0;
  logic       ack_force = 1'b0;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = ack_force | (mem_req && (wcnt >= lat_wait));
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Monitor: pc_enable pulses, accepted instructions, request-hold violations.
  int         pe_cnt = 0;
  int         acc_cnt = 0;
  int         drop_err = 0;
  logic       r_pend = 1'b0;
  logic [7:0] r_paddr = 8'h00;
  always @(posedge clk) begin
    if (reset) begin
      pe_cnt   <= 0;
      acc_cnt  <= 0;
      drop_err <= 0;
      r_pend   <= 1'b0;
    end else begin
      if (pc_enable) pe_cnt <= pe_cnt + 1;
      if (ir_valid && ir_ready) acc_cnt <= acc_cnt + 1;
      if (r_pend && !branch_taken && (!mem_req || mem_addr != r_paddr)) drop_err <= drop_err + 1;
      r_pend  <= mem_req && !mem_ack;
      r_paddr <= mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    while (!ir_valid && n < max) begin
      tick();
      n++;
    end
    check(tag, {31'd0, ir_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ir_ready = 1'b1; branch_taken = 1'b0; branch_target = 8'h00; halt = 1'b0;
    mem_clear();
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h83; mem[8'h02] = 8'h2A;
    #2;

    // Reset state
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_pc_en",     {31'd0, pc_enable}, 32'd0);
    check("rst_ir_valid",  {31'd0, ir_valid},  32'd0);
    check("rst_opcode",    {24'd0, ir_opcode}, 32'h00);
    check("rst_operand",   {24'd0, ir_operand},32'h00);
    check("rst_ir_pc",     {24'd0, ir_pc},     32'h00);

    // Zero-wait: 05 (short) then 83 2A (long)
    lat_wait = 0;
    do_reset();
    check("zw_c0_req",     {31'd0, mem_req},   32'd1);
    check("zw_c0_addr",    {24'd0, mem_addr},  32'h00);
    check("zw_c0_pe",      {31'd0, pc_enable}, 32'd1);
    check("zw_c0_next",    {24'd0, pc_next},   32'h01);
    tick();
    check("zw_i0_valid",   {31'd0, ir_valid},  32'd1);
    check("zw_i0_opc",     {24'd0, ir_opcode}, 32'h05);
    check("zw_i0_opr",     {24'd0, ir_operand},32'h00);
    check("zw_i0_pc",      {24'd0, ir_pc},     32'h00);
    check("zw_i0_req",     {31'd0, mem_req},   32'd0);
    check("zw_i0_pe",      {31'd0, pc_enable}, 32'd0);
    check("zw_i0_nextpc",  {24'd0, pc_next},   32'h01);
    tick();
    check("zw_c2_addr",    {24'd0, mem_addr},  32'h01);
    check("zw_c2_next",    {24'd0, pc_next},   32'h02);
    tick();
    check("zw_c3_opr_req", {31'd0, mem_req},   32'd1);
    check("zw_c3_next",    {24'd0, pc_next},   32'h03);
    tick();
    check("zw_i1_valid",   {31'd0, ir_valid},  32'd1);
    check("zw_i1_opc",     {24'd0, ir_opcode}, 32'h83);
    check("zw_i1_opr",     {24'd0, ir_operand},32'h2A);
    check("zw_i1_pc",      {24'd0, ir_pc},     32'h01);
    check("zw_pc",         {24'd0, pc},        32'h03);

    // 3-cycle ack latency with a 4-cycle decoder stall
    lat_wait = 2; ir_ready = 1'b0;
    do_reset();
    check("sl_c0_req",     {31'd0, mem_req},   32'd1);
    check("sl_c0_pe",      {31'd0, pc_enable}, 32'd0);
    tick();
    check("sl_c1_req",     {31'd0, mem_req},   32'd1);
    check("sl_c1_addr",    {24'd0, mem_addr},  32'h00);
    check("sl_c1_pe",      {31'd0, pc_enable}, 32'd0);
    tick();
    check("sl_c2_pe",      {31'd0, pc_enable}, 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("sl_stall_valid", {31'd0, ir_valid},  32'd1);
      check("sl_stall_opc",   {24'd0, ir_opcode}, 32'h05);
      check("sl_stall_pc",    {24'd0, ir_pc},     32'h00);
      check("sl_stall_req",   {31'd0, mem_req},   32'd0);
      tick();
    end
    ir_ready = 1'b1;
    tick();
    wait_valid("sl_i1_wait", 20);
    check("sl_i1_opc",     {24'd0, ir_opcode}, 32'h83);
    check("sl_i1_opr",     {24'd0, ir_operand},32'h2A);
    check("sl_i1_pc",      {24'd0, ir_pc},     32'h01);
    check("sl_pe_count",   pe_cnt,             32'd3);
    check("sl_req_hold",   drop_err,           32'd0);

    // Branch on the same cycle as the operand ack
    lat_wait = 0;
    mem_clear();
    mem[8'h00] = 8'h83; mem[8'h01] = 8'h2A; mem[8'h40] = 8'h11;
    do_reset();
    tick();
    branch_taken = 1'b1; branch_target = 8'h40; ack_force = 1'b1;
    #1;
    check("br_req",        {31'd0, mem_req},   32'd0);
    check("br_pe",         {31'd0, pc_enable}, 32'd1);
    check("br_next",       {24'd0, pc_next},   32'h40);
    tick();
    branch_taken = 1'b0; ack_force = 1'b0;
    #1;
    check("br_valid",      {31'd0, ir_valid},  32'd0);
    check("br_pc",         {24'd0, pc},        32'h40);
    check("br_addr",       {24'd0, mem_addr},  32'h40);
    check("br_req_after",  {31'd0, mem_req},   32'd1);
    check("br_no_accept",  acc_cnt,            32'd0);
    tick();
    check("br_i_opc",      {24'd0, ir_opcode}, 32'h11);
    check("br_i_opr",      {24'd0, ir_operand},32'h00);
    check("br_i_pc",       {24'd0, ir_pc},     32'h40);

    // PC wrap at FF
    mem_clear();
    mem[8'hFF] = 8'h22;
    do_reset();
    branch_taken = 1'b1; branch_target = 8'hFF;
    #1;
    check("wr_br_next",    {24'd0, pc_next},   32'hFF);
    tick();
    branch_taken = 1'b0;
    #1;
    check("wr_addr",       {24'd0, mem_addr},  32'hFF);
    check("wr_next",       {24'd0, pc_next},   32'h00);
    check("wr_pe",         {31'd0, pc_enable}, 32'd1);
    tick();
    check("wr_ir_pc",      {24'd0, ir_pc},     32'hFF);
    check("wr_opc",        {24'd0, ir_opcode}, 32'h22);
    check("wr_pc",         {24'd0, pc},        32'h00);

    // Halt during the operand fetch
    mem_clear();
    mem[8'h00] = 8'h83; mem[8'h01] = 8'h2A; mem[8'h02] = 8'h07;
    do_reset();
    tick();
    halt = 1'b1;
    #1;
    check("hl_opr_req",    {31'd0, mem_req},   32'd1);
    check("hl_opr_pe",     {31'd0, pc_enable}, 32'd1);
    tick();
    check("hl_valid",      {31'd0, ir_valid},  32'd1);
    check("hl_opc",        {24'd0, ir_opcode}, 32'h83);
    check("hl_opr",        {24'd0, ir_operand},32'h2A);
    tick();
    check("hl_h_req",      {31'd0, mem_req},   32'd0);
    check("hl_h_valid",    {31'd0, ir_valid},  32'd0);
    check("hl_h_pc",       {24'd0, pc},        32'h02);
    check("hl_accepted",   acc_cnt,            32'd1);
    ack_force = 1'b1;
    #1;
    check("hl_stray_ack",  {31'd0, pc_enable}, 32'd0);
    tick();
    ack_force = 1'b0;
    check("hl_h_pc2",      {24'd0, pc},        32'h02);
    halt = 1'b0;
    #1;
    check("hl_rel_req",    {31'd0, mem_req},   32'd0);
    tick();
    check("hl_res_req",    {31'd0, mem_req},   32'd1);
    check("hl_res_addr",   {24'd0, mem_addr},  32'h02);

    // Reset while waiting for an ack
    mem_clear();
    mem[8'h00] = 8'h05;
    lat_wait = 2;
    do_reset();
    tick();
    check("rw_pend_req",   {31'd0, mem_req},   32'd1);
    reset = 1'b1;
    #1;
    check("rw_req",        {31'd0, mem_req},   32'd0);
    check("rw_valid",      {31'd0, ir_valid},  32'd0);
    check("rw_pe",         {31'd0, pc_enable}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rw_re_req",     {31'd0, mem_req},   32'd1);
    check("rw_re_addr",    {24'd0, mem_addr},  32'h00);
    check("rw_re_pe",      pe_cnt,             32'd0);
    wait_valid("rw_wait", 20);
    check("rw_opc",        {24'd0, ir_opcode}, 32'h05);
    check("rw_ir_pc",      {24'd0, ir_pc},     32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
